// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec -- ALU execute stage behind the arithmetic-logic decoder.
//
// Single-cycle ops (add/sub/and/or/xor/slt/sltu) register their result on
// accept. Shifts (sll/srl/sra) run through a 1-bit-per-cycle serial shifter,
// and the stage holds in_ready low while the shift is in progress.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream offers an operation
//   in_ready   out  stage can accept this cycle (depends on out_ready)
//   op         in   11-bit one-hot op code (bit10 reserved)
//   op_valid   in   decoder valid flag for op
//   a          in   operand A / shift source
//   b          in   operand B; b[SHW-1:0] is the shift amount
//   out_valid  out  result available
//   out_ready  in   downstream accepts result
//   result     out  registered result
//   err        out  illegal op indicator (result forced to 0)
// -----------------------------------------------------------------------------
module alu_exec #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [10:0]     op,
    input  logic            op_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t            state;
    state_t            state_next;
    shkind_t           kind;
    logic [XLEN-1:0]   work;
    logic [SHW-1:0]    cnt;
    logic              fill;

    logic              legal;
    logic              is_shift;
    logic              accept;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   work_step;

    function automatic logic [XLEN-1:0] alu_single(
        input logic [10:0]     o,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic signed [XLEN-1:0] xs;
        logic signed [XLEN-1:0] ys;
        logic [XLEN-1:0]        r;
        xs = x;
        ys = y;
        r  = '0;
        if (o[0])      r = x + y;
        else if (o[1]) r = x - y;
        else if (o[2]) r = x & y;
        else if (o[3]) r = x | y;
        else if (o[4]) r = x ^ y;
        else if (o[8]) r = {{(XLEN-1){1'b0}}, (xs < ys)};
        else if (o[9]) r = {{(XLEN-1){1'b0}}, (x < y)};
        return r;
    endfunction

    function automatic logic [XLEN-1:0] shift_step(
        input logic [XLEN-1:0] w,
        input shkind_t         k,
        input logic            f
    );
        logic [XLEN-1:0] r;
        case (k)
            SH_LL:   r = {w[XLEN-2:0], 1'b0};
            SH_RL:   r = {1'b0, w[XLEN-1:1]};
            default: r = {f, w[XLEN-1:1]};
        endcase
        return r;
    endfunction

    // Legal means exactly one bit set, not the reserved bit, and flagged valid.
    assign legal    = op_valid && (op != 11'd0) && ((op & (op - 11'd1)) == 11'd0) && !op[10];
    assign is_shift = legal && (op[5] || op[6] || op[7]);
    assign shamt    = b[SHW-1:0];

    // in_ready looks through to out_ready so HOLD can drain and refill in one cycle.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign work_step = shift_step(work, kind, fill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (is_shift && shamt != '0) ? SHIFT : HOLD;
            end
            SHIFT: begin
                if (cnt == SHW'(1)) state_next = HOLD;
            end
            HOLD: begin
                if (accept)         state_next = (is_shift && shamt != '0) ? SHIFT : HOLD;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            err    <= 1'b0;
            work   <= '0;
            cnt    <= '0;
            kind   <= SH_LL;
            fill   <= 1'b0;
        end else if (accept) begin
            err <= !legal;
            if (!legal) begin
                result <= '0;
            end else if (is_shift) begin
                work <= a;
                cnt  <= shamt;
                kind <= op[5] ? SH_LL : (op[6] ? SH_RL : SH_RA);
                fill <= a[XLEN-1];
                // Zero shift amount finishes immediately with the source value.
                if (shamt == '0) result <= a;
            end else begin
                result <= alu_single(op, a, b);
            end
        end else if (state == SHIFT) begin
            work <= work_step;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) result <= work_step;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    localparam logic [10:0] OP_ADD  = 11'h001;
    localparam logic [10:0] OP_SUB  = 11'h002;
    localparam logic [10:0] OP_AND  = 11'h004;
    localparam logic [10:0] OP_OR   = 11'h008;
    localparam logic [10:0] OP_XOR  = 11'h010;
    localparam logic [10:0] OP_SLL  = 11'h020;
    localparam logic [10:0] OP_SRL  = 11'h040;
    localparam logic [10:0] OP_SRA  = 11'h080;
    localparam logic [10:0] OP_SLT  = 11'h100;
    localparam logic [10:0] OP_SLTU = 11'h200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] op;
    logic        op_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        err;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   seen  = 0;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_valid  (op_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: first appearance checks latency, handshake checks data.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_output result=%h err=%b with nothing pending", result, err);
            end else begin
                if (!seen) begin
                    seen = 1;
                    tests++;
                    if (cyc - q[0].cyc !== q[0].lat) begin
                        fails++;
                        $display("FAIL latency got %0d exp %0d", cyc - q[0].cyc, q[0].lat);
                    end
                end
                if (out_ready) begin
                    tests++;
                    if (result !== q[0].res || err !== q[0].err) begin
                        fails++;
                        $display("FAIL result got %h/%b exp %h/%b", result, err, q[0].res, q[0].err);
                    end
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    function automatic logic [31:0] model(input logic [10:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Present one operation and hold it until accepted; called just after a posedge.
    task automatic issue(input logic [10:0] o, input logic ov, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic ee, input int lat, input bit push, output int waits);
        exp_t e;
        in_valid = 1; op = o; op_valid = ov; a = av; b = bv;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout in_ready stuck at 0 for %0d cycles", waits);
        end else if (push) begin
            e.res = er; e.err = ee; e.cyc = cyc; e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; op = '0; op_valid = 0; a = '0; b = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 32'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state got ov=%b res=%h err=%b rdy=%b exp 0/0/0/1", out_valid, result, err, in_ready);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int w;
        bit bad;
        issue(OP_SLL, 1, 32'h1, 32'd20, 32'h0, 0, 0, 0, w);
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_shift got ov=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        q.delete();
        seen = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL stale_after_reset got out_valid=1 exp 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int w;
        int wsum;
        logic [10:0] ops [7];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU};
        out_ready = 1;
        wsum = 0;
        issue(OP_ADD,  1, 32'hFFFFFFFF, 32'h1, 32'h00000000, 0, 1, 1, w); wsum += w;
        issue(OP_SUB,  1, 32'h0,        32'h1, 32'hFFFFFFFF, 0, 1, 1, w); wsum += w;
        issue(OP_SLT,  1, 32'h80000000, 32'h1, 32'h1,        0, 1, 1, w); wsum += w;
        issue(OP_SLTU, 1, 32'h80000000, 32'h1, 32'h0,        0, 1, 1, w); wsum += w;
        for (int i = 0; i < 16; i++) begin
            logic [10:0] o;
            logic [31:0] x;
            logic [31:0] y;
            o = ops[$urandom_range(0, 6)];
            x = $urandom;
            y = (i % 4 == 0) ? x : $urandom;
            issue(o, 1, x, y, model(o, x, y), 0, 1, 1, w); wsum += w;
        end
        in_valid = 0;
        tests++;
        if (wsum !== 0) begin
            fails++;
            $display("FAIL stream_throughput got %0d stall cycles exp 0", wsum);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_shift(input logic [10:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [31:0] er);
        int w;
        int n;
        int k;
        out_ready = 1;
        issue(o, 1, av, bv, er, 0, 32, 1, w);
        in_valid = 0;
        n = 0; k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            if (!in_ready) n++;
            k++;
            @(negedge clk);
        end
        tests++;
        if (!out_valid || n !== 31) begin
            fails++;
            $display("FAIL shift_ready_low op=%h got %0d cycles ov=%b exp 31", o, n, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_zero();
        int w;
        out_ready = 1;
        issue(OP_SRA, 1, 32'h80001234, 32'h20, 32'h80001234, 0, 1, 1, w);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int w;
        bit bad;
        out_ready = 0;
        issue(OP_ADD, 1, 32'd3, 32'd4, 32'd7, 0, 1, 1, w);
        in_valid = 0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL hold_stable got ov=%b res=%h rdy=%b exp 1/00000007/0", out_valid, result, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1;
        issue(OP_ADD, 1, 32'd5, 32'd5, 32'd10, 0, 1, 1, w);
        in_valid = 0;
        tests++;
        if (w !== 0) begin
            fails++;
            $display("FAIL hold_refill_ready got %0d stalls exp 0", w);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || result !== 32'd10) begin
            fails++;
            $display("FAIL no_bubble got ov=%b res=%h exp 1/0000000a", out_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        int w;
        out_ready = 1;
        issue(11'h000, 1, 32'h5, 32'h6, 32'h0, 1, 1, 1, w);
        issue(11'h003, 1, 32'h5, 32'h6, 32'h0, 1, 1, 1, w);
        issue(11'h400, 1, 32'h5, 32'h6, 32'h0, 1, 1, 1, w);
        issue(OP_ADD,  0, 32'h5, 32'h6, 32'h0, 1, 1, 1, w);
        issue(OP_ADD,  1, 32'h5, 32'h6, 32'hB, 0, 1, 1, w);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_stream();
        test_shift(OP_SLL, 32'h00000001, 32'h0000003F, 32'h80000000);
        test_shift(OP_SRL, 32'h80000000, 32'd31,       32'h00000001);
        test_shift(OP_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF);
        test_shift_zero();
        test_backpressure();
        test_illegal();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the arithmetic-logic decoder. Consumes the 11-bit one-hot ALU op code, the decoder's valid flag and two XLEN operands, and produces a registered result over a valid/ready handshake.
- add/sub/and/or/xor/slt/sltu complete in one cycle.
- sll/srl/sra use a serial 1-bit-per-cycle shifter to save area, so the stage applies backpressure upstream while shifting.

Parameters:
- XLEN, 32, operand/result width. Must be a power of two, 8 or larger.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  stage can accept this cycle.
- op  in  11  one-hot code. bit0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 reserved.
- op_valid  in  1  decoder valid flag for op.
- a  in  XLEN  operand A / shift source.
- b  in  XLEN  operand B; b[SHW-1:0] is the shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  registered result.
- err  out  1  qualifies result: illegal op (result forced 0).

Behaviour:
- Reset: async assert on rst_n low; release is synchronous to clk.
  - state=IDLE, out_valid=0, result=0, err=0, shift counter=0.
  - in_ready=1 after reset.
  - A reset mid-shift or mid-hold discards the operation; nothing is emitted.
- States:
  - IDLE: empty.
  - SHIFT: serial shift in progress.
  - HOLD: result valid, awaiting out_ready.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready). This gives back-to-back throughput of 1 per cycle for single-cycle ops.
- Illegal op: op_valid==0, op not exactly one-hot, or op[10]==1.
  - Accepted like a single-cycle op; HOLD with result=0, err=1.
- Single-cycle ops (bits 0-4, 8, 9): on accept, result is registered, err=0, state moves to HOLD. out_valid rises the next cycle, so latency is 1.
  - add/sub: modulo 2^XLEN; no flags.
  - slt: signed compare; sltu: unsigned compare. Result is {XLEN-1 zeros, lt}.
- Shift ops (bits 5-7):
  - On accept, load a into the working register and b[SHW-1:0] into the counter. b upper bits are ignored.
  - If the count is 0, go directly to HOLD with result=a (latency 1).
  - Otherwise go to SHIFT. Each cycle the working register shifts by 1 and the counter decrements. When the counter reaches 0, the result is registered and state moves to HOLD.
  - Total latency = 1 + shamt cycles. Maximum is XLEN for shamt = XLEN-1.
  - sll shifts left, zero-fill. srl shifts right, zero-fill. sra shifts right, filling with a[XLEN-1] captured at accept.
  - in_ready=0 throughout SHIFT.
- HOLD: out_valid=1. result and err are stable until out_ready.
  - On out_ready with no new accept, go to IDLE with out_valid=0.
  - On out_ready with a simultaneous accept: a single-cycle op or shamt=0 stays in HOLD with new data, and out_valid stays 1. A shift with shamt>0 goes to SHIFT with out_valid=0.
- Outputs are registered only; no combinational path from in_* to out_*. in_ready depends combinationally on out_ready (documented).
- Inputs outside an accept cycle are ignored. Operands are captured on accept, so upstream may change them afterwards.

Test Plan:
- Reset with rst_n low mid-SHIFT (sll, shamt 20, after 5 cycles) -> out_valid=0 and in_ready=1 immediately; no stale result appears after release.
- Streaming add/sub/slt/sltu, out_ready held 1:
  - add 0xFFFFFFFF+1 -> 0x00000000.
  - sub 0-1 -> 0xFFFFFFFF.
  - slt(0x80000000, 1) -> 1.
  - sltu(0x80000000, 1) -> 0.
  - Required: one result per cycle, latency 1.
- Shifts, all with latency 32:
  - sll a=0x00000001 b=0x0000003F (shamt 31) -> 0x80000000.
  - srl a=0x80000000 shamt 31 -> 0x00000001.
  - sra a=0x80000000 shamt 31 -> 0xFFFFFFFF.
  - Required: in_ready=0 for 31 cycles.
- Shift by 0: sra a=0x8000_1234 b=0x20 (shamt field 0) -> result 0x80001234, latency 1.
- Backpressure: out_ready=0 for 4 cycles after an add of 3+4 -> result=7 is held stable and in_ready=0. When out_ready rises with in_valid add 5+5 -> 7 is consumed, 10 appears the next cycle, and no bubble occurs.
- Illegal ops: op=0x000, op=0x003, op=0x400, or op_valid=0 -> result=0, err=1, latency 1. A following legal op has err=0.
